ticket_ctrl: RTL and testbench

TICKET_CTRL -- requirements
Module: ticket_ctrl

---
 rtl/ticket_pkg.sv | 54 +++++
 rtl/ticket_coin_acc.sv | 42 ++++
 rtl/ticket_ctrl.sv | 150 +++++++++++++++
 tb/tb_ticket_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ticket_pkg.sv
// Shared definitions for the ticket vending controller: state codes, fares,
// coin values and the fare x quantity helper.
package ticket_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_PAY      = 3'd2,
    ST_DISPENSE = 3'd3,
    ST_CHANGE   = 3'd4
  } state_t;

  localparam logic [7:0] FARE_ZONE1 = 8'd10;
  localparam logic [7:0] FARE_ZONE2 = 8'd20;
  localparam logic [7:0] FARE_ZONE3 = 8'd30;
  localparam logic [7:0] FARE_ZONE4 = 8'd40;

  localparam logic [7:0] COIN_5  = 8'd5;
  localparam logic [7:0] COIN_10 = 8'd10;
  localparam logic [7:0] COIN_20 = 8'd20;
  localparam logic [7:0] COIN_50 = 8'd50;

  function automatic logic [7:0] coin_value(input logic [1:0] sel);
    logic [7:0] v;
    case (sel)
      2'b00:   v = COIN_5;
      2'b01:   v = COIN_10;
      2'b10:   v = COIN_20;
      default: v = COIN_50;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] fare_of(input logic [2:0] zone);
    logic [7:0] f;
    case (zone)
      3'd1:    f = FARE_ZONE1;
      3'd2:    f = FARE_ZONE2;
      3'd3:    f = FARE_ZONE3;
      3'd4:    f = FARE_ZONE4;
      default: f = 8'd0;
    endcase
    return f;
  endfunction

  // Large selections (zone 4 with qty above 6) exceed 8 bits; clamp to 255
  // so the fare can still be met by a full credit register.
  function automatic logic [7:0] total_of(input logic [2:0] zone, input logic [2:0] qty);
    logic [10:0] prod;
    prod = {3'b000, fare_of(zone)} * {8'b0000_0000, qty};
    return (prod > 11'd255) ? 8'hFF : prod[7:0];
  endfunction

endpackage

// File: rtl/ticket_coin_acc.sv
// Credit accumulator: decodes the coin, refuses coins that would overflow
// the 8-bit credit, and pulses coin_reject for every refused coin.
module ticket_coin_acc
  import ticket_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [1:0] coin_sel,
  input  logic       accept_en,
  input  logic       clear,
  output logic       accept,
  output logic [7:0] credit,
  output logic       coin_reject
);

  logic [7:0] value;
  logic [8:0] sum;
  logic [7:0] credit_reg;
  logic       coin_reject_reg;

  assign value  = coin_value(coin_sel);
  assign sum    = {1'b0, credit_reg} + {1'b0, value};
  assign accept = coin_valid && accept_en && !sum[8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_reg      <= 8'd0;
      coin_reject_reg <= 1'b0;
    end else begin
      coin_reject_reg <= coin_valid && !accept;
      if (clear)
        credit_reg <= 8'd0;
      else if (accept)
        credit_reg <= sum[7:0];
    end
  end

  assign credit      = credit_reg;
  assign coin_reject = coin_reject_reg;

endmodule

// File: rtl/ticket_ctrl.sv
// Ticket vending controller: zone/quantity selection, payment, ticket
// dispensing and change/refund, driven by scanned keys and coin strobes.
module ticket_ctrl
  import ticket_pkg::*;
#(
  parameter int MAX_QTY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_rdy,
  input  logic [7:0] key_code,
  input  logic       coin_valid,
  input  logic [1:0] coin_sel,
  output logic [2:0] state,
  output logic [7:0] total,
  output logic [7:0] credit,
  output logic       coin_reject,
  output logic       key_err,
  output logic       ticket_out,
  output logic       change_valid,
  output logic [7:0] change_amt
);

  localparam logic [2:0] QTY_MAX = 3'(MAX_QTY);

  state_t     state_reg, state_next;
  logic [2:0] zone_reg, zone_next;
  logic [2:0] qty_reg, qty_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       refund_reg, refund_next;
  logic [7:0] total_reg;
  logic       key_err_reg;

  logic       key_ok, zone_key, qty_key, cancel_key;
  logic [2:0] zone_sel;
  logic       coin_en, coin_accept, credit_clear;

  // A key is usable only when exactly one of the six defined bits is set.
  assign key_ok     = key_rdy && (key_code[7:6] == 2'b00) && $onehot(key_code[5:0]);
  assign zone_key   = key_ok && (key_code[3:0] != 4'b0000);
  assign qty_key    = key_ok && key_code[4];
  assign cancel_key = key_ok && key_code[5];

  always_comb begin
    zone_sel = 3'd4;
    if (key_code[0])      zone_sel = 3'd1;
    else if (key_code[1]) zone_sel = 3'd2;
    else if (key_code[2]) zone_sel = 3'd3;
  end

  ticket_coin_acc u_coin_acc (
    .clk        (clk),
    .rst        (rst),
    .coin_valid (coin_valid),
    .coin_sel   (coin_sel),
    .accept_en  (coin_en),
    .clear      (credit_clear),
    .accept     (coin_accept),
    .credit     (credit),
    .coin_reject(coin_reject)
  );

  always_comb begin
    state_next   = state_reg;
    zone_next    = zone_reg;
    qty_next     = qty_reg;
    cnt_next     = cnt_reg;
    refund_next  = refund_reg;
    coin_en      = 1'b0;
    credit_clear = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (zone_key) begin
          zone_next  = zone_sel;
          qty_next   = 3'd1;
          state_next = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (cancel_key) begin
          zone_next  = 3'd0;
          qty_next   = 3'd0;
          state_next = ST_IDLE;
        end else begin
          coin_en = 1'b1;
          if (zone_key) zone_next = zone_sel;
          if (qty_key)  qty_next  = (qty_reg >= QTY_MAX) ? 3'd1 : qty_reg + 3'd1;
          if (coin_accept) state_next = ST_PAY;
        end
      end
      ST_PAY: begin
        // Cancel takes priority over a coin arriving in the same cycle.
        if (cancel_key) begin
          refund_next = 1'b1;
          state_next  = ST_CHANGE;
        end else begin
          coin_en = 1'b1;
          if (credit >= total_reg) begin
            cnt_next   = 3'd1;
            state_next = ST_DISPENSE;
          end
        end
      end
      ST_DISPENSE: begin
        if (cnt_reg >= qty_reg) begin
          refund_next = 1'b0;
          state_next  = ST_CHANGE;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      ST_CHANGE: begin
        credit_clear = 1'b1;
        zone_next    = 3'd0;
        qty_next     = 3'd0;
        refund_next  = 1'b0;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      zone_reg    <= 3'd0;
      qty_reg     <= 3'd0;
      cnt_reg     <= 3'd0;
      refund_reg  <= 1'b0;
      total_reg   <= 8'd0;
      key_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      zone_reg    <= zone_next;
      qty_reg     <= qty_next;
      cnt_reg     <= cnt_next;
      refund_reg  <= refund_next;
      total_reg   <= total_of(zone_next, qty_next);
      key_err_reg <= key_rdy && !key_ok;
    end
  end

  assign state        = state_reg;
  assign total        = total_reg;
  assign key_err      = key_err_reg;
  assign ticket_out   = (state_reg == ST_DISPENSE);
  assign change_valid = (state_reg == ST_CHANGE);
  assign change_amt   = !change_valid ? 8'd0 : (refund_reg ? credit : credit - total_reg);

endmodule

// File: tb/tb_ticket_ctrl.sv
// Scoreboard bench for ticket_ctrl: two instances (MAX_QTY 4 and 7) share the
// stimulus; a reference model queues expected outputs that monitors compare.
module tb_ticket_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] total;
    logic [7:0] credit;
    logic       crej;
    logic       kerr;
    logic       tick;
    logic       cv;
    logic [7:0] camt;
  } obs_t;

  typedef struct {
    int st;
    int zone;
    int qty;
    int credit;
    int total;
    int left;
    int chg;
  } mdl_t;

  logic       clk, rst, key_rdy, coin_valid;
  logic [7:0] key_code;
  logic [1:0] coin_sel;

  logic [2:0] st4, st7;
  logic [7:0] total4, total7, credit4, credit7, camt4, camt7;
  logic       crej4, crej7, kerr4, kerr7, tick4, tick7, cv4, cv7;
  obs_t       act4, act7;

  int   n_cmp = 0;
  int   n_bad = 0;
  obs_t q4[$];
  obs_t q7[$];
  mdl_t m4, m7;

  ticket_ctrl #(.MAX_QTY(4)) dut4 (
    .clk(clk), .rst(rst), .key_rdy(key_rdy), .key_code(key_code),
    .coin_valid(coin_valid), .coin_sel(coin_sel), .state(st4), .total(total4),
    .credit(credit4), .coin_reject(crej4), .key_err(kerr4), .ticket_out(tick4),
    .change_valid(cv4), .change_amt(camt4)
  );

  ticket_ctrl #(.MAX_QTY(7)) dut7 (
    .clk(clk), .rst(rst), .key_rdy(key_rdy), .key_code(key_code),
    .coin_valid(coin_valid), .coin_sel(coin_sel), .state(st7), .total(total7),
    .credit(credit7), .coin_reject(crej7), .key_err(kerr7), .ticket_out(tick7),
    .change_valid(cv7), .change_amt(camt7)
  );

  assign act4 = {st4, total4, credit4, crej4, kerr4, tick4, cv4, camt4};
  assign act7 = {st7, total7, credit7, crej7, kerr7, tick7, cv7, camt7};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d total=%0d credit=%0d rej=%0b kerr=%0b tick=%0b cv=%0b amt=%0d",
                     o.st, o.total, o.credit, o.crej, o.kerr, o.tick, o.cv, o.camt);
  endfunction

  task automatic compare(input string tag, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got {%s} expected {%s}", tag, $time, fmt(act), fmt(exp));
    end else begin
      $display("ok   %s @%0t: %s", tag, $time, fmt(act));
    end
  endtask

  // Behavioural reference: one clock of the vending rules, returning the
  // outputs visible after that clock edge.
  task automatic model_step(input mdl_t m, input int maxq, input logic kr, input logic [7:0] kc,
                            input logic cv, input logic [1:0] cs, output mdl_t n, output obs_t e);
    bit good, zk, qk, ck, acc;
    int zsel, val, t;
    int coin_vals[4] = '{5, 10, 20, 50};
    n    = m;
    good = kr && (kc[7:6] == 2'b00) && ($countones(kc[5:0]) == 1);
    zk   = good && (kc[3:0] != 4'b0);
    qk   = good && kc[4];
    ck   = good && kc[5];
    zsel = kc[0] ? 1 : kc[1] ? 2 : kc[2] ? 3 : 4;
    val  = coin_vals[cs];
    acc  = 1'b0;
    case (m.st)
      0: if (zk) begin n.zone = zsel; n.qty = 1; n.st = 1; end
      1: if (ck) begin
           n.st = 0; n.zone = 0; n.qty = 0;
         end else begin
           if (zk) n.zone = zsel;
           if (qk) n.qty = (m.qty % maxq) + 1;
           if (cv && (m.credit + val <= 255)) begin acc = 1'b1; n.st = 2; end
         end
      2: if (ck) begin
           n.st = 4; n.chg = m.credit;
         end else begin
           if (cv && (m.credit + val <= 255)) acc = 1'b1;
           if (m.credit >= m.total) begin n.st = 3; n.left = m.qty - 1; end
         end
      3: if (m.left == 0) begin n.st = 4; n.chg = m.credit - m.total; end
         else n.left = m.left - 1;
      default: begin n.st = 0; n.zone = 0; n.qty = 0; n.credit = 0; end
    endcase
    if (acc) n.credit = m.credit + val;
    t = n.zone * 10 * n.qty;
    n.total  = (t > 255) ? 255 : t;
    e.st     = 3'(n.st);
    e.total  = 8'(n.total);
    e.credit = 8'(n.credit);
    e.crej   = cv && !acc;
    e.kerr   = kr && !good;
    e.tick   = (n.st == 3);
    e.cv     = (n.st == 4);
    e.camt   = (n.st == 4) ? 8'(n.chg) : 8'd0;
  endtask

  task automatic drive(input logic kr, input logic [7:0] kc, input logic cv, input logic [1:0] cs);
    obs_t e;
    @(negedge clk);
    key_rdy = kr; key_code = kc; coin_valid = cv; coin_sel = cs;
    model_step(m4, 4, kr, kc, cv, cs, m4, e);
    q4.push_back(e);
    model_step(m7, 7, kr, kc, cv, cs, m7, e);
    q7.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 2'b00);
  endtask

  task automatic key(input logic [7:0] kc);
    drive(1'b1, kc, 1'b0, 2'b00);
  endtask

  task automatic coin(input logic [1:0] cs);
    drive(1'b0, 8'h00, 1'b1, cs);
  endtask

  // Asynchronous reset takes effect mid-cycle; outputs are checked before any edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    key_rdy = 1'b0; key_code = 8'h00; coin_valid = 1'b0; coin_sel = 2'b00;
    m4 = '{default: 0};
    m7 = '{default: 0};
    #1;
    compare("reset_q4", act4, obs_t'(0));
    compare("reset_q7", act7, obs_t'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor4
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q4.size() > 0) begin
        e = q4.pop_front();
        compare("q4", act4, e);
      end
    end
  end

  initial begin : monitor7
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q7.size() > 0) begin
        e = q7.pop_front();
        compare("q7", act7, e);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached with %0d/%0d records pending", q4.size(), q7.size());
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    int r;
    logic [7:0] kc;
    rst = 1'b0; key_rdy = 1'b0; key_code = 8'h00; coin_valid = 1'b0; coin_sel = 2'b00;
    m4 = '{default: 0};
    m7 = '{default: 0};
    do_reset();

    // zone 2, two 10 coins: exact payment, one ticket, zero change
    key(8'h02); coin(2'b01); coin(2'b01); idle(4);
    // zone 4, qty 3, three 50 coins: three tickets, change 30
    key(8'h08); key(8'h10); key(8'h10); coin(2'b11); coin(2'b11); coin(2'b11); idle(6);
    // qty wrap after four increments, then cancel from SELECT
    key(8'h04); key(8'h10); key(8'h10); key(8'h10); key(8'h10); idle(1); key(8'h20); idle(1);
    // refund of partial payment, then coin while idle
    key(8'h01); coin(2'b00); key(8'h20); idle(2); coin(2'b10); idle(2);
    // invalid key code leaves state alone
    key(8'h02); key(8'h14); key(8'hC0); key(8'h20); idle(1);
    // credit 230 + 50 refused on the MAX_QTY=7 instance, then pay 255 exactly
    key(8'h08);
    for (int i = 0; i < 6; i++) key(8'h10);
    for (int i = 0; i < 4; i++) coin(2'b11);
    coin(2'b10); coin(2'b01); coin(2'b11); coin(2'b10); coin(2'b00); idle(14);
    // key and coin together in SELECT, then cancel and coin together in PAY
    drive(1'b1, 8'h08, 1'b1, 2'b11); drive(1'b1, 8'h20, 1'b1, 2'b11); idle(2);
    // reset during the second ticket pulse
    key(8'h01); key(8'h10); coin(2'b10); idle(2); do_reset(); idle(3);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        r = $urandom_range(0, 15);
        if (r < 8)       kc = 8'h01 << (r % 4);
        else if (r < 12) kc = 8'h10;
        else if (r == 12) kc = 8'h20;
        else             kc = 8'($urandom_range(0, 255));
        drive($urandom_range(0, 3) == 0, kc, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)));
      end
    end
    idle(1);
    @(negedge clk);
    @(negedge clk);

    n_cmp++;
    if (q4.size() != 0 || q7.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending records q4=%0d q7=%0d, required 0", q4.size(), q7.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
